// File: rtl/v_issue_queue_if.sv
// Scalar-to-vector instruction handshake bundle for v_issue_queue.
// slave = queue side, master = core/bench side.
interface v_issue_queue_if #(
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 32
);
  logic               s_valid_i;
  logic [INSTR_W-1:0] s_instr_i;
  logic [DATA_W-1:0]  s_rs1_i;
  logic [DATA_W-1:0]  s_rs2_i;
  logic               s_ready_o;
  logic               v_valid_o;
  logic [INSTR_W-1:0] v_instr_o;
  logic [DATA_W-1:0]  v_rs1_o;
  logic [DATA_W-1:0]  v_rs2_o;
  logic               v_ready_i;

  modport slave (
    input  s_valid_i, s_instr_i, s_rs1_i, s_rs2_i,
    output s_ready_o,
    output v_valid_o, v_instr_o, v_rs1_o, v_rs2_o,
    input  v_ready_i
  );

  modport master (
    output s_valid_i, s_instr_i, s_rs1_i, s_rs2_i,
    input  s_ready_o,
    input  v_valid_o, v_instr_o, v_rs1_o, v_rs2_o,
    output v_ready_i
  );
endinterface

// File: rtl/v_issue_queue.sv
// Vector issue FIFO with load/store pending counters and scalar memory grants.
// Optional V_ISSUE_BYPASS_EN: empty-queue same-cycle fall-through.
module v_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            rstn,
  v_issue_queue_if.slave  q,
  output logic            vector_stall_o,
  input  logic            v_ld_done_i,
  input  logic            v_st_done_i,
  output logic            all_v_loads_executed_o,
  output logic            all_v_stores_executed_o,
  input  logic            scalar_load_req_i,
  input  logic            scalar_store_req_i,
  output logic            scalar_load_grant_o,
  output logic            scalar_store_grant_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [6:0] OP_LD = 7'b0000111;
  localparam logic [6:0] OP_ST = 7'b0100111;
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  rs1;
    logic [DATA_W-1:0]  rs2;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q;
  logic [CNT_W-1:0] ld_pend_q, ld_pend_d;
  logic [CNT_W-1:0] st_pend_q, st_pend_d;
  logic             ld_zero_q, st_zero_q;

  logic   is_ld, is_st, empty, ready;
  logic   enq, deq, byp, byp_take, wr, rd;
  entry_t head;

  function automatic logic [CNT_W-1:0] pend_next(
    input logic [CNT_W-1:0] p,
    input logic             inc,
    input logic             done
  );
    logic [CNT_W-1:0] n;
    n = p;
    unique case (1'b1)
      inc && !done:                n = p + CNT_W'(1);
      !inc && done && p != '0:     n = p - CNT_W'(1);
      default:                     n = p;
    endcase
    return n;
  endfunction

  assign is_ld = (q.s_instr_i[6:0] == OP_LD);
  assign is_st = (q.s_instr_i[6:0] == OP_ST);
  assign empty = (cnt_q == '0);

  // When full, ready relies on the head being popped this cycle.
  assign ready = (!full_q || q.v_ready_i)
               && !(is_ld && ld_pend_q == PEND_MAX)
               && !(is_st && st_pend_q == PEND_MAX);

  assign enq = q.s_valid_i && ready;

`ifdef V_ISSUE_BYPASS_EN
  assign byp = empty && q.s_valid_i && ready;
`else
  assign byp = 1'b0;
`endif

  assign head = mem_q[rd_ptr_q];

  assign q.s_ready_o = ready;
  assign vector_stall_o = !ready;
  assign q.v_valid_o = !empty || byp;
  assign q.v_instr_o = byp ? q.s_instr_i : head.instr;
  assign q.v_rs1_o   = byp ? q.s_rs1_i   : head.rs1;
  assign q.v_rs2_o   = byp ? q.s_rs2_i   : head.rs2;

  assign deq      = q.v_valid_o && q.v_ready_i;
  assign byp_take = byp && q.v_ready_i;
  assign wr       = enq && !byp_take;
  assign rd       = deq && !byp_take;

  always_comb begin
    cnt_d     = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    ld_pend_d = pend_next(ld_pend_q, enq && is_ld, v_ld_done_i);
    st_pend_d = pend_next(st_pend_q, enq && is_st, v_st_done_i);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      ld_pend_q <= '0;
      st_pend_q <= '0;
      ld_zero_q <= 1'b1;
      st_zero_q <= 1'b1;
    end else begin
      if (wr) begin
        mem_q[wr_ptr_q] <= '{instr: q.s_instr_i,
                             rs1:   q.s_rs1_i,
                             rs2:   q.s_rs2_i};
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q     <= cnt_d;
      full_q    <= (cnt_d == CNT_FULL);
      ld_pend_q <= ld_pend_d;
      st_pend_q <= st_pend_d;
      ld_zero_q <= (ld_pend_d == '0);
      st_zero_q <= (st_pend_d == '0);
    end
  end

  assign all_v_loads_executed_o  = ld_zero_q;
  assign all_v_stores_executed_o = st_zero_q;

  // Loads wait on older stores; stores wait on both.
  assign scalar_load_grant_o  = scalar_load_req_i && (st_pend_q == '0);
  assign scalar_store_grant_o = scalar_store_req_i && (st_pend_q == '0)
                              && (ld_pend_q == '0);

endmodule

// File: tb/tb_v_issue_queue.sv
// Scoreboard bench for v_issue_queue (DEPTH=4, CNT_W=2).
// Popped heads are checked by a monitor against queued expectations.
module tb_v_issue_queue;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic v_ld_done, v_st_done;
  logic ld_req, st_req;
  logic stall, ld_exec, st_exec, ld_gnt, st_gnt;

  v_issue_queue_if #(.INSTR_W(32), .DATA_W(32)) q_if ();

  v_issue_queue #(
    .DEPTH(4), .INSTR_W(32), .DATA_W(32), .CNT_W(2)
  ) dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .q                      (q_if.slave),
    .vector_stall_o         (stall),
    .v_ld_done_i            (v_ld_done),
    .v_st_done_i            (v_st_done),
    .all_v_loads_executed_o (ld_exec),
    .all_v_stores_executed_o(st_exec),
    .scalar_load_req_i      (ld_req),
    .scalar_store_req_i     (st_req),
    .scalar_load_grant_o    (ld_gnt),
    .scalar_store_grant_o   (st_gnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  int vecs = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && q_if.v_valid_o && q_if.v_ready_i) begin
      if (sb.size() == 0) begin
        vecs++;
        fails++;
        $display("FAIL pop_unexpected: got %h want none", q_if.v_instr_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pop_instr", q_if.v_instr_o, e.i);
        chk("pop_rs1", q_if.v_rs1_o, e.a);
        chk("pop_rs2", q_if.v_rs2_o, e.b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b);
    bit ok = 0;
    q_if.s_valid_i = 1'b1;
    q_if.s_instr_i = ins;
    q_if.s_rs1_i   = a;
    q_if.s_rs2_i   = b;
    sb.push_back('{i: ins, a: a, b: b});
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (q_if.s_ready_o) begin
        tick();
        ok = 1;
      end
    end
    if (!ok) begin
      vecs++;
      fails++;
      $display("FAIL push_timeout: got ready=0 want ready=1 for %h", ins);
      void'(sb.pop_back());
    end
    q_if.s_valid_i = 1'b0;
  endtask

  task automatic done_pulse(input bit st);
    if (st) v_st_done = 1'b1; else v_ld_done = 1'b1;
    tick();
    v_st_done = 1'b0;
    v_ld_done = 1'b0;
  endtask

  task automatic drain();
    q_if.v_ready_i = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    q_if.s_valid_i = 1'b0;
    q_if.s_instr_i = '0;
    q_if.s_rs1_i   = '0;
    q_if.s_rs2_i   = '0;
    q_if.v_ready_i = 1'b0;
    v_ld_done = 1'b0;
    v_st_done = 1'b0;
    ld_req = 1'b0;
    st_req = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    chk("rst_ready", 32'(q_if.s_ready_o), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_vvalid", 32'(q_if.v_valid_o), 32'd0);
    chk("rst_vinstr", q_if.v_instr_o, 32'h0);
    chk("rst_vrs1", q_if.v_rs1_o, 32'h0);
    chk("rst_ld_exec", 32'(ld_exec), 32'd1);
    chk("rst_st_exec", 32'(st_exec), 32'd1);
    chk("rst_ld_gnt", 32'(ld_gnt), 32'd0);
    chk("rst_st_gnt", 32'(st_gnt), 32'd0);
    ld_req = 1'b1;
    st_req = 1'b1;
    #1;
    chk("idle_ld_gnt", 32'(ld_gnt), 32'd1);
    chk("idle_st_gnt", 32'(st_gnt), 32'd1);
    ld_req = 1'b0;
    st_req = 1'b0;

    // fill to full with the consumer stalled
    for (int k = 0; k < 4; k++)
      push(32'h57 + 32'(k) * 32'h100, 32'h100 + 32'(k), 32'h200 + 32'(k));
    chk("full_ready", 32'(q_if.s_ready_o), 32'd0);
    chk("full_stall", 32'(stall), 32'd1);
    chk("full_head", q_if.v_instr_o, 32'h57);
    repeat (2) tick();
    chk("hold_head", q_if.v_instr_o, 32'h57);

    // push and pop together while full
    q_if.v_ready_i = 1'b1;
    push(32'h457, 32'h104, 32'h204);
    q_if.v_ready_i = 1'b0;
    #1;
    chk("still_full", 32'(q_if.s_ready_o), 32'd0);
    chk("wrap_head", q_if.v_instr_o, 32'h157);
    drain();

    // store blocks scalar loads until its done pulse
    push(32'h27, 32'h1000, 32'h0);
    chk("st_exec_low", 32'(st_exec), 32'd0);
    ld_req = 1'b1;
    #1;
    chk("ld_gnt_blk", 32'(ld_gnt), 32'd0);
    repeat (2) tick();
    chk("ld_gnt_blk2", 32'(ld_gnt), 32'd0);
    done_pulse(1'b1);
    chk("st_exec_high", 32'(st_exec), 32'd1);
    chk("ld_gnt_ok", 32'(ld_gnt), 32'd1);
    ld_req = 1'b0;

    // load counter saturation at 3
    for (int k = 0; k < 3; k++) push(32'h07, 32'(k), 32'h0);
    chk("ld_exec_low", 32'(ld_exec), 32'd0);
    st_req = 1'b1;
    ld_req = 1'b1;
    #1;
    chk("st_gnt_blk", 32'(st_gnt), 32'd0);
    chk("ld_gnt_st0", 32'(ld_gnt), 32'd1);
    st_req = 1'b0;
    ld_req = 1'b0;
    q_if.s_valid_i = 1'b1;
    q_if.s_instr_i = 32'h107;
    q_if.s_rs1_i   = 32'h3;
    q_if.s_rs2_i   = 32'h0;
    sb.push_back('{i: 32'h107, a: 32'h3, b: 32'h0});
    @(negedge clk);
    chk("sat_ready", 32'(q_if.s_ready_o), 32'd0);
    chk("sat_stall", 32'(stall), 32'd1);
    tick();
    v_ld_done = 1'b1;
    @(negedge clk);
    chk("sat_ready_done", 32'(q_if.s_ready_o), 32'd0);
    tick();
    v_ld_done = 1'b0;
    chk("sat_pend2", 32'(dut.ld_pend_q), 32'd2);
    @(negedge clk);
    chk("sat_ready_rel", 32'(q_if.s_ready_o), 32'd1);
    tick();
    q_if.s_valid_i = 1'b0;
    chk("sat_pend3", 32'(dut.ld_pend_q), 32'd3);
    done_pulse(1'b0);
    v_ld_done = 1'b1;
    push(32'h207, 32'h5, 32'h6);
    v_ld_done = 1'b0;
    chk("simul_pend", 32'(dut.ld_pend_q), 32'd2);
    drain();

    // async reset mid-stream
    done_pulse(1'b0);
    done_pulse(1'b0);
    chk("ld_exec_back", 32'(ld_exec), 32'd1);
    q_if.v_ready_i = 1'b0;
    push(32'h307, 32'h7, 32'h8);
    push(32'h407, 32'h9, 32'ha);
    chk("pre_rst_pend", 32'(dut.ld_pend_q), 32'd2);
    #1;
    rstn = 1'b0;
    #1;
    chk("arst_vvalid", 32'(q_if.v_valid_o), 32'd0);
    chk("arst_ld_exec", 32'(ld_exec), 32'd1);
    chk("arst_vinstr", q_if.v_instr_o, 32'h0);
    sb.delete();
    #1;
    rstn = 1'b1;
    tick();
    done_pulse(1'b0);
    chk("post_rst_pend", 32'(dut.ld_pend_q), 32'd0);
    chk("post_rst_exec", 32'(ld_exec), 32'd1);

`ifdef V_ISSUE_BYPASS_EN
    q_if.v_ready_i = 1'b1;
    q_if.s_valid_i = 1'b1;
    q_if.s_instr_i = 32'h02208057;
    q_if.s_rs1_i   = 32'h11;
    q_if.s_rs2_i   = 32'h22;
    sb.push_back('{i: 32'h02208057, a: 32'h11, b: 32'h22});
    #1;
    chk("byp_valid", 32'(q_if.v_valid_o), 32'd1);
    chk("byp_instr", q_if.v_instr_o, 32'h02208057);
    tick();
    q_if.s_valid_i = 1'b0;
    #1;
    chk("byp_empty", 32'(q_if.v_valid_o), 32'd0);
`endif

    repeat (2) tick();
    chk("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
